demux_reg: RTL and testbench
============================

# demux_reg

Registered one-to-many demultiplexer: the distribution counterpart of the `Mux` selector tree. It accepts one `DATA_WIDTH` word stream and steers each word into one of `2**SWITCH_BITS` output lanes. Each lane holds its word in a one-entry register with its own valid/ready handshake. The block fans a shared datapath bus out to parallel consumers (e.g. per-neuron input registers), either by explicit select or in automatic round-robin order.

## Interface
Parameters:
- `SWITCH_BITS`, 1, select width; lane count `N = 2**SWITCH_BITS`.
- `DATA_WIDTH`, 8, word width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept the word on this cycle.
- `in_sel`  in  `SWITCH_BITS`  target lane when `seq_en`=0.
- `in_data`  in  `DATA_WIDTH`  input word.
- `seq_en`  in  1  1: target comes from internal round-robin pointer; 0: target is `in_sel`.
- `cur_sel`  out  `SWITCH_BITS`  current target lane: `seq_en ? ptr : in_sel`.
- `out_data`  out  `N*DATA_WIDTH`  lane i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid`  out  `N`  lane i holds an unconsumed word.
- `out_ready`  in  `N`  consumer of lane i takes its word this cycle.

## Operation
- State:
  - per-lane `full[i]` and `data[i]`;
  - round-robin pointer `ptr` (`SWITCH_BITS` bits).
- Signal definitions:
  - `out_valid[i] = full[i]` and `out_data` lane i = `data[i]`, both driven directly from registers.
  - Target `t = cur_sel`.
  - `in_ready = ~full[t] | out_ready[t]`. This is combinational from `seq_en`, `in_sel`, `ptr`, `full` and `out_ready`.
  - Accept `acc = in_valid & in_ready`.
  - Pop `pop[i] = full[i] & out_ready[i]`.
- Per-lane update each edge:
  - `acc` and `t==i`: `data[i] <= in_data`, `full[i] <= 1`. This applies even if `pop[i]` in the same cycle, so a back-to-back stream sustains 1 word/cycle on one lane.
  - otherwise `pop[i]`: `full[i] <= 0`; `data[i]` holds its last value.
  - otherwise: hold.
- Lanes other than `t` pop independently in the same cycle as an accept.
- Pointer:
  - `seq_en` & `acc`: `ptr <= ptr + 1` modulo N, so N-1 wraps to 0.
  - `seq_en`=0: `ptr` holds and `in_sel` is used.
  - Toggling `seq_en` does not reset `ptr`; round-robin resumes where it left off.
- Blocking:
  - A full, unpopped target lane blocks input (`in_ready`=0) even if other lanes are empty. There is no reordering and no skip-ahead.
  - `in_data` is ignored when `acc`=0.
- SWITCH_BITS=0 is not supported; minimum is 1.

## Timing
- Reset (`rst`=0, asynchronous): `full`=0, all `data`=0, `ptr`=0.
  - Immediately: `out_valid`=0, `out_data`=0.
  - `cur_sel`=0 if `seq_en`=1, else it follows `in_sel`.
  - `in_ready`=1 while `rst` is low; any `in_valid` during reset is not accepted.
- Reset deassertion is synchronised externally. The first accept can occur on the first rising edge with `rst`=1.
- Latency: word accepted at edge k appears on `out_valid`/`out_data` right after edge k (visible in cycle k+1). It is consumable at edge k+1 at the earliest.
- Throughput:
  - 1 word/cycle when the targeted lane is empty or popped in the same cycle.
  - With `seq_en`=1 and all `out_ready`=1, sustained 1 word/cycle across lanes.
- Reset mid-operation: pending lane words are discarded; the upstream must resend.
- Producer rule: hold `in_valid`, `in_data` and `in_sel` stable until `acc`.
- Consumer rule: `out_data[i]` is stable while `out_valid[i]`=1 and not popped.

## Test plan
All scenarios use SWITCH_BITS=2 (N=4), DATA_WIDTH=8.
- Reset: drive `rst`=0 mid-cycle with lanes 1 and 3 full -> `out_valid`=4'b0000 and `out_data`=0 without waiting for a clock edge; `cur_sel`=0 with `seq_en`=1.
- Explicit select: `seq_en`=0; send 0xA1 to sel 2 with `out_ready`=0 -> `out_valid`=4'b0100, lane 2=0xA1. A second word to sel 2 sees `in_ready`=0, while a word to sel 0 is accepted the same cycle.
- Simultaneous push/pop: lane 2 full with 0xA1, `out_ready[2]`=1, send 0xB2 to sel 2 -> `in_ready`=1; next cycle lane 2=0xB2 and `out_valid[2]`=1 with no bubble.
- Round-robin wrap: `seq_en`=1, all `out_ready`=1; send 0x10..0x15 on consecutive cycles -> lanes receive 0,1,2,3,0,1 in order; `ptr`=2 afterwards.
- Blocking: `seq_en`=1, `ptr`=1, lane 1 full, `out_ready`=0 -> `in_ready`=0 and `ptr` stays 1. Raising `out_ready[1]` -> accept that cycle, then `ptr`=2.
- Mode switch: after `ptr` reaches 3, set `seq_en`=0 and send to sel 0, then set `seq_en`=1 -> the next round-robin word goes to lane 3.

Source files
------------

// File: rtl/demux_reg_if.sv
// demux_reg_if: bus bundle for the registered one-to-many demultiplexer.
//
// Purpose: groups the input word stream (valid/ready/select/data), the
// round-robin mode control and the per-lane output handshakes into one
// interface so the demultiplexer and its driver share a single port.
//
// Signals (N = 2**SWITCH_BITS lanes):
//   in_valid   producer -> demux   input word present
//   in_ready   demux -> producer   target lane can take the word this cycle
//   in_sel     producer -> demux   target lane when seq_en = 0
//   in_data    producer -> demux   input word
//   seq_en     producer -> demux   1: round-robin target, 0: in_sel target
//   cur_sel    demux -> producer   lane currently targeted
//   out_data   demux -> lanes      lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  demux -> lanes      lane i holds an unconsumed word
//   out_ready  lanes -> demux      consumer of lane i takes its word
//
// Modports: master = producer/consumer side, slave = demultiplexer side.
interface demux_reg_if #(
  parameter int SWITCH_BITS = 1,
  parameter int DATA_WIDTH  = 8
);
  localparam int N = 2 ** SWITCH_BITS;

  logic                    in_valid;
  logic                    in_ready;
  logic [SWITCH_BITS-1:0]  in_sel;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    seq_en;
  logic [SWITCH_BITS-1:0]  cur_sel;
  logic [N*DATA_WIDTH-1:0] out_data;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;

  modport master (
    output in_valid, in_sel, in_data, seq_en, out_ready,
    input  in_ready, cur_sel, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_sel, in_data, seq_en, out_ready,
    output in_ready, cur_sel, out_data, out_valid
  );
endinterface

// File: rtl/demux_reg.sv
// demux_reg: registered one-to-many demultiplexer.
//
// Purpose: steers each word of a single input stream into one of
// 2**SWITCH_BITS one-entry lane registers, chosen either by an explicit
// select or by an internal round-robin pointer. Each lane has its own
// valid/ready handshake towards its consumer.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-low reset; clears lanes and pointer
//   bus   demux_reg_if.slave (input stream, mode control, lane outputs)
module demux_reg #(
  parameter int SWITCH_BITS = 1,
  parameter int DATA_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  demux_reg_if.slave  bus
);
  localparam int N = 2 ** SWITCH_BITS;

  logic [N-1:0]                 full_q, full_d;
  logic [N-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [SWITCH_BITS-1:0]       ptr_q, ptr_d;

  logic [SWITCH_BITS-1:0]       target;
  logic                         accept;
  logic [N-1:0]                 pop;

  assign target       = bus.seq_en ? ptr_q : bus.in_sel;
  assign bus.cur_sel  = target;

  // A lane being drained this cycle frees its slot for the incoming word,
  // which is what lets one lane sustain a word per cycle.
  assign bus.in_ready = ~full_q[target] | bus.out_ready[target];
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = full_q & bus.out_ready;

  assign bus.out_valid = full_q;
  assign bus.out_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ptr_d  = ptr_q;
    for (int i = 0; i < N; i++) begin
      // A push wins over a pop on the same lane so the slot stays occupied.
      if (accept && (target == SWITCH_BITS'(i))) begin
        data_d[i] = bus.in_data;
        full_d[i] = 1'b1;
      end else if (pop[i]) begin
        full_d[i] = 1'b0;
      end
    end
    // Pointer wraps naturally at N because it is exactly SWITCH_BITS wide.
    if (bus.seq_en && accept) begin
      ptr_d = ptr_q + SWITCH_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
    end
  end
endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: directed self-checking bench for demux_reg with four
// 8-bit lanes. Inputs change on the falling clock edge; combinational
// outputs are sampled just after that, registered outputs just after
// the rising edge.
module tb_demux_reg;
  localparam int SB = 2;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_reg_if #(.SWITCH_BITS(SB), .DATA_WIDTH(DW)) bus ();

  demux_reg #(.SWITCH_BITS(SB), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane(input int i);
    return bus.out_data[i*DW +: DW];
  endfunction

  task automatic afterPos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic seq, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.seq_en    = seq;
    bus.out_ready = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'hEE, 1'b0, 4'b0000);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0000", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    afterPos();
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_no_accept: got %b expected 0000", bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'h55, 1'b0, 4'b0000);
    afterPos();
    @(negedge clk);
    drive(1'b1, 2'd3, 8'h66, 1'b0, 4'b0000);
    afterPos();
    checks++;
    if (bus.out_valid !== 4'b1010 || bus.out_data !== 32'h6600_5500) begin
      errors++; $display("[TB] FAIL prefill: got %b/%h expected 1010/66005500",
                         bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset: got %b/%h expected 0000/00000000",
                         bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.cur_sel !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_cur_sel_seq: got %0d expected 0", bus.cur_sel);
    end
    bus.seq_en = 1'b0;
    bus.in_sel = 2'd2;
    #1;
    checks++;
    if (bus.cur_sel !== 2'd2) begin
      errors++; $display("[TB] FAIL reset_cur_sel_sel: got %0d expected 2", bus.cur_sel);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
  endtask

  task automatic test_explicit_select();
    @(negedge clk);
    drive(1'b1, 2'd2, 8'hA1, 1'b0, 4'b0000);
    afterPos();
    checks++;
    if (bus.out_valid !== 4'b0100 || lane(2) !== 8'hA1) begin
      errors++; $display("[TB] FAIL sel_push: got %b/%h expected 0100/a1", bus.out_valid, lane(2));
    end
    @(negedge clk);
    drive(1'b1, 2'd2, 8'hC3, 1'b0, 4'b0000);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL sel_block: got %b expected 0", bus.in_ready);
    end
    bus.in_sel  = 2'd0;
    bus.in_data = 8'h0F;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL sel_other_ready: got %b expected 1", bus.in_ready);
    end
    afterPos();
    checks++;
    if (bus.out_valid !== 4'b0101 || lane(0) !== 8'h0F || lane(2) !== 8'hA1) begin
      errors++; $display("[TB] FAIL sel_other_push: got %b/%h/%h expected 0101/0f/a1",
                         bus.out_valid, lane(0), lane(2));
    end
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    drive(1'b1, 2'd2, 8'hB2, 1'b0, 4'b0100);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL pp_ready: got %b expected 1", bus.in_ready);
    end
    afterPos();
    checks++;
    if (bus.out_valid !== 4'b0101 || lane(2) !== 8'hB2) begin
      errors++; $display("[TB] FAIL pp_no_bubble: got %b/%h expected 0101/b2", bus.out_valid, lane(2));
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0101);
    afterPos();
    checks++;
    if (bus.out_valid !== 4'b0000 || lane(0) !== 8'h0F || lane(2) !== 8'hB2) begin
      errors++; $display("[TB] FAIL pp_drain: got %b/%h/%h expected 0000/0f/b2",
                         bus.out_valid, lane(0), lane(2));
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expV;
    logic [7:0] expD;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      expD = 8'h10 + 8'(k);
      drive(1'b1, 2'd0, expD, 1'b1, 4'b1111);
      #1;
      checks++;
      if (bus.cur_sel !== 2'(k % 4)) begin
        errors++; $display("[TB] FAIL rr_sel%0d: got %0d expected %0d", k, bus.cur_sel, k % 4);
      end
      afterPos();
      expV = 4'b0001 << (k % 4);
      checks++;
      if (bus.out_valid !== expV || lane(k % 4) !== expD) begin
        errors++; $display("[TB] FAIL rr_lane%0d: got %b/%h expected %b/%h",
                           k, bus.out_valid, lane(k % 4), expV, expD);
      end
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 4'b1111);
    #1;
    checks++;
    if (bus.cur_sel !== 2'd2) begin
      errors++; $display("[TB] FAIL rr_ptr_after: got %0d expected 2", bus.cur_sel);
    end
  endtask

  task automatic test_blocking();
    // Advance pointer 2 -> 1 through lanes 2, 3, 0 with all lanes draining.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 2'd0, 8'h30 + 8'(k), 1'b1, 4'b1111);
    end
    @(negedge clk);
    drive(1'b1, 2'd1, 8'h77, 1'b0, 4'b0000);
    afterPos();
    @(negedge clk);
    drive(1'b1, 2'd0, 8'h88, 1'b1, 4'b0000);
    #1;
    checks++;
    if (bus.cur_sel !== 2'd1 || bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL blk_stall: got sel %0d ready %b expected 1/0",
                         bus.cur_sel, bus.in_ready);
    end
    afterPos();
    checks++;
    if (bus.cur_sel !== 2'd1 || lane(1) !== 8'h77) begin
      errors++; $display("[TB] FAIL blk_hold: got %0d/%h expected 1/77", bus.cur_sel, lane(1));
    end
    @(negedge clk);
    bus.out_ready = 4'b0010;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL blk_release: got %b expected 1", bus.in_ready);
    end
    afterPos();
    checks++;
    if (bus.out_valid[1] !== 1'b1 || lane(1) !== 8'h88 || bus.cur_sel !== 2'd2) begin
      errors++; $display("[TB] FAIL blk_accept: got %b/%h/%0d expected 1/88/2",
                         bus.out_valid[1], lane(1), bus.cur_sel);
    end
  endtask

  task automatic test_mode_switch();
    @(negedge clk);
    drive(1'b1, 2'd0, 8'h44, 1'b1, 4'b1111);
    afterPos();
    checks++;
    if (bus.cur_sel !== 2'd3) begin
      errors++; $display("[TB] FAIL ms_ptr3: got %0d expected 3", bus.cur_sel);
    end
    @(negedge clk);
    drive(1'b1, 2'd0, 8'h99, 1'b0, 4'b0000);
    #1;
    checks++;
    if (bus.cur_sel !== 2'd0) begin
      errors++; $display("[TB] FAIL ms_explicit_sel: got %0d expected 0", bus.cur_sel);
    end
    afterPos();
    checks++;
    if (lane(0) !== 8'h99) begin
      errors++; $display("[TB] FAIL ms_explicit_push: got %h expected 99", lane(0));
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000);
    #1;
    checks++;
    if (bus.cur_sel !== 2'd3) begin
      errors++; $display("[TB] FAIL ms_resume: got %0d expected 3", bus.cur_sel);
    end
    @(negedge clk);
    drive(1'b1, 2'd0, 8'hAA, 1'b1, 4'b0000);
    afterPos();
    checks++;
    if (bus.out_valid[3] !== 1'b1 || lane(3) !== 8'hAA || bus.cur_sel !== 2'd0) begin
      errors++; $display("[TB] FAIL ms_rr_push: got %b/%h/%0d expected 1/aa/0",
                         bus.out_valid[3], lane(3), bus.cur_sel);
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_explicit_select();
    test_push_pop();
    test_round_robin();
    test_blocking();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
